// File: rtl/sad_acc_16_if.sv
// sad_acc_16_if: pixel-beat input and SAD-result output handshake bundle for sad_acc_16
//   pix_valid/pix_ready : pixel beat handshake (cur_pix, ref_pix with 16 lanes)
//   sad_valid/sad_ready : result handshake (sad_array with 16 packed SAD elements)
//   master drives beats and consumes results; slave is the accumulator.
interface sad_acc_16_if #(
    parameter int PIXEL_BIT_DEPTH   = 8,
    parameter int ELEMENT_BIT_DEPTH = 14
);
    logic                            pix_valid;
    logic                            pix_ready;
    logic [PIXEL_BIT_DEPTH-1:0]      cur_pix;
    logic [PIXEL_BIT_DEPTH*16-1:0]   ref_pix;
    logic                            sad_valid;
    logic                            sad_ready;
    logic [ELEMENT_BIT_DEPTH*16-1:0] sad_array;

    modport master (
        output pix_valid, cur_pix, ref_pix, sad_ready,
        input  pix_ready, sad_valid, sad_array
    );

    modport slave (
        input  pix_valid, cur_pix, ref_pix, sad_ready,
        output pix_ready, sad_valid, sad_array
    );
endinterface

// File: rtl/sad_acc_16.sv
// sad_acc_16: accumulates 16 parallel saturating SADs per block and holds the result for MIN_16
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : sad_acc_16_if slave (pixel beats in, packed SAD array out)
module sad_acc_16 #(
    parameter int PIXEL_BIT_DEPTH   = 8,
    parameter int BLOCK_PIXELS      = 64,
    parameter int ELEMENT_BIT_DEPTH = 14
) (
    input logic        clk,
    input logic        rst_n,
    sad_acc_16_if.slave bus
);
    localparam int P  = PIXEL_BIT_DEPTH;
    localparam int E  = ELEMENT_BIT_DEPTH;
    localparam int CW = $clog2(BLOCK_PIXELS);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [16*E-1:0] acc, acc_nxt;
    logic [P-1:0]  r, d;
    logic [E:0]    s;
    logic          beat, last;

    assign beat          = bus.pix_valid && state == ACCUM;
    assign last          = cnt == CW'(BLOCK_PIXELS - 1);
    assign bus.pix_ready = state == ACCUM;
    assign bus.sad_valid = state == HOLD;
    assign bus.sad_array = acc;

    always_comb begin
        state_nxt = state;
        if (state == ACCUM)
            state_nxt = beat && last ? HOLD : ACCUM;
        else
            state_nxt = bus.sad_ready ? ACCUM : HOLD;
    end

    // One extra sum bit catches the carry out; a set carry clamps the lane to all-ones.
    always_comb begin
        acc_nxt = '0;
        r = '0;
        d = '0;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            r = bus.ref_pix[P*i +: P];
            d = bus.cur_pix > r ? bus.cur_pix - r : r - bus.cur_pix;
            s = {1'b0, acc[E*i +: E]} + (E+1)'(d);
            acc_nxt[E*i +: E] = s[E] ? '1 : s[E-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                cnt <= last ? '0 : cnt + 1'b1;
                acc <= acc_nxt;
            end else if (state == HOLD && bus.sad_ready) begin
                acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sad_acc_16.sv
// tb_sad_acc_16: directed self-checking bench with a per-cycle behavioural SAD model
module tb_sad_acc_16;
    logic clk = 0;
    logic rst_n = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 0;

    always #5 clk = ~clk;

    sad_acc_16_if #(.PIXEL_BIT_DEPTH(8), .ELEMENT_BIT_DEPTH(14)) b ();
    sad_acc_16_if #(.PIXEL_BIT_DEPTH(8), .ELEMENT_BIT_DEPTH(14)) b2 ();

    sad_acc_16 #(.PIXEL_BIT_DEPTH(8), .BLOCK_PIXELS(64), .ELEMENT_BIT_DEPTH(14)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
    sad_acc_16 #(.PIXEL_BIT_DEPTH(8), .BLOCK_PIXELS(128), .ELEMENT_BIT_DEPTH(14)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] min16(input logic [223:0] a);
        logic [13:0] m;
        logic [3:0]  k;
        m = a[13:0];
        k = 0;
        for (int i = 1; i < 16; i++)
            if (a[14*i +: 14] < m) begin
                m = a[14*i +: 14];
                k = 4'(i);
            end
        return {k, m};
    endfunction

    function automatic int absd(input logic [7:0] x, input logic [7:0] y);
        return x > y ? int'(x) - int'(y) : int'(y) - int'(x);
    endfunction

    // Behavioural model: plain integer sums per block, clamped only when presented.
    int   m_sum [16];
    int   m_n;
    bit   m_hold;
    logic [223:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold <= 0;
            m_n <= 0;
            for (int i = 0; i < 16; i++) m_sum[i] <= 0;
        end else if (m_hold) begin
            if (b.sad_ready) begin
                m_hold <= 0;
                for (int i = 0; i < 16; i++) m_sum[i] <= 0;
            end
        end else if (b.pix_valid) begin
            for (int i = 0; i < 16; i++) m_sum[i] <= m_sum[i] + absd(b.cur_pix, b.ref_pix[8*i +: 8]);
            m_n <= (m_n == 63) ? 0 : m_n + 1;
            if (m_n == 63) m_hold <= 1;
        end
    end

    always_comb begin
        m_exp = '0;
        for (int i = 0; i < 16; i++) m_exp[14*i +: 14] = m_sum[i] > 16383 ? 14'h3FFF : 14'(m_sum[i]);
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_pix_ready", 256'(b.pix_ready), 256'(!m_hold));
            chk("model_sad_valid", 256'(b.sad_valid), 256'(m_hold));
            chk("model_sad_array", 256'(b.sad_array), 256'(m_exp));
        end
    end

    task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] r);
        @(posedge clk); #1;
        b.pix_valid = v;
        b.cur_pix = c;
        b.ref_pix = r;
    endtask

    task automatic run_block(input logic [7:0] c, input logic [127:0] r);
        for (int k = 0; k < 64; k++) drive(1, c, r);
        @(negedge clk);
        chk("valid_not_early", 256'(b.sad_valid), 256'(0));
        drive(0, c, r);
        @(negedge clk);
    endtask

    task automatic release_result();
        @(posedge clk); #1;
        b.sad_ready = 1;
        @(posedge clk); #1;
        b.sad_ready = 0;
        @(negedge clk);
        chk("release_ready", 256'(b.pix_ready), 256'(1));
        chk("release_clear", 256'(b.sad_array), 256'(0));
    endtask

    logic [127:0] r;
    logic [17:0]  mi;
    logic [223:0] res [2];
    int nacc, nres, t64, t65, p;
    logic [3:0] pat;

    initial begin
        b.pix_valid = 0; b.cur_pix = 0; b.ref_pix = '0; b.sad_ready = 0;
        b2.pix_valid = 0; b2.cur_pix = 0; b2.ref_pix = '0; b2.sad_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 256'(b.pix_ready), 256'(1));
        chk("reset_valid", 256'(b.sad_valid), 256'(0));
        chk("reset_array", 256'(b.sad_array), 256'(0));
        @(posedge clk); #3;
        rst_n = 1;
        chk_en = 1;

        // 1: all-zero block
        run_block(8'd0, '0);
        chk("t1_valid", 256'(b.sad_valid), 256'(1));
        chk("t1_array", 256'(b.sad_array), 256'(0));
        mi = min16(b.sad_array);
        chk("t1_min16", 256'(mi), 256'({4'd0, 14'd0}));
        release_result();

        // 2: cur 200, lane i = 10*i
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(10 * i);
        run_block(8'd200, r);
        chk("t2_lane0", 256'(b.sad_array[13:0]), 256'(14'h3200));
        chk("t2_lane15", 256'(b.sad_array[223:210]), 256'(14'h0C80));
        mi = min16(b.sad_array);
        chk("t2_min16", 256'(mi), 256'({4'd15, 14'h0C80}));
        release_result();

        // 3: largest unsaturated result, then 4: backpressure on it
        run_block(8'd255, '0);
        chk("t3_full", 256'(b.sad_array), 256'({16{14'h3FC0}}));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            b.pix_valid = 1'($urandom);
            b.cur_pix = 8'($urandom);
            b.ref_pix = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("t4_hold_array", 256'(b.sad_array), 256'({16{14'h3FC0}}));
            chk("t4_hold_ready", 256'(b.pix_ready), 256'(0));
        end
        @(posedge clk); #1;
        b.pix_valid = 0;
        release_result();

        // 3b: 128-pixel block saturates every lane
        for (int k = 0; k < 128; k++) begin
            @(posedge clk); #1;
            b2.pix_valid = 1; b2.cur_pix = 8'd255; b2.ref_pix = '0;
        end
        @(posedge clk); #1;
        b2.pix_valid = 0;
        @(negedge clk);
        chk("t3b_valid", 256'(b2.sad_valid), 256'(1));
        chk("t3b_sat", 256'(b2.sad_array), 256'({16{14'h3FFF}}));

        // 5: bubbles, back-to-back blocks with sad_ready tied high
        @(posedge clk); #1;
        b.sad_ready = 1;
        pat = 4'b1001;
        nacc = 0; nres = 0; t64 = -1; t65 = -1; p = 0;
        for (int cyc = 0; cyc < 400 && nres < 2; cyc++) begin
            @(negedge clk);
            if (b.sad_valid) begin
                res[nres] = b.sad_array;
                nres++;
            end
            if (b.pix_valid && b.pix_ready) begin
                nacc++;
                if (nacc == 64) t64 = cyc;
                if (nacc == 65) t65 = cyc;
            end
            @(posedge clk); #1;
            if (nacc >= 128) b.pix_valid = 0;
            else if (nacc == 64) b.pix_valid = 1;
            else begin
                b.pix_valid = pat[p % 4];
                p++;
            end
            if (nacc < 64) begin
                b.cur_pix = 8'd100;
                for (int i = 0; i < 16; i++) b.ref_pix[8*i +: 8] = 8'(5 * i);
            end else begin
                b.cur_pix = 8'd0;
                for (int i = 0; i < 16; i++) b.ref_pix[8*i +: 8] = 8'(i);
            end
        end
        chk("t5_results", 256'(nres), 256'(2));
        chk("t5_spacing", 256'(t65 - t64), 256'(2));
        chk("t5_a_lane0", 256'(res[0][13:0]), 256'(14'h1900));
        chk("t5_a_lane15", 256'(res[0][223:210]), 256'(14'h0640));
        chk("t5_b_lane0", 256'(res[1][13:0]), 256'(14'h0000));
        chk("t5_b_lane15", 256'(res[1][223:210]), 256'(14'h03C0));
        @(posedge clk); #1;
        b.pix_valid = 0;
        b.sad_ready = 0;

        // 6: asynchronous reset mid-block
        for (int k = 0; k < 30; k++) drive(1, 8'd50, '0);
        drive(0, 8'd0, '0);
        @(negedge clk);
        chk("t6_partial", 256'(b.sad_array[13:0]), 256'(14'd1500));
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("t6_rst_ready", 256'(b.pix_ready), 256'(1));
        chk("t6_rst_valid", 256'(b.sad_valid), 256'(0));
        chk("t6_rst_array", 256'(b.sad_array), 256'(0));
        #1;
        rst_n = 1;
        run_block(8'd77, {16{8'd77}});
        chk("t6_valid", 256'(b.sad_valid), 256'(1));
        chk("t6_zero", 256'(b.sad_array), 256'(0));
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
